// File: rtl/store_narrower.sv
// -----------------------------------------------------------------------------
// store_narrower
// MEM-stage store path: narrows a 32-bit register operand into a word-aligned
// data-memory write (address, lane-replicated data, byte enables). Misaligned
// and reserved-size stores are consumed but dropped, raising a one-cycle
// misalign pulse. Accepted stores are queued in a small circular FIFO that
// drains toward the data-memory port with a valid/ready handshake.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  request handshake (ready is purely occupancy based)
//   in_addr         byte address
//   in_data         register operand (rt)
//   in_size         00 byte, 01 half, 10 word, 11 reserved
//   out_valid/ready FIFO head handshake toward memory
//   out_addr        word-aligned address of head
//   out_wdata       lane-replicated write data of head
//   out_be          byte enables of head (bit i = lane i)
//   misalign        one-cycle pulse after a faulting request is consumed
//   misalign_addr   byte address of the most recent faulting request
// -----------------------------------------------------------------------------
module store_narrower #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_size,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_wdata,
   output logic [3:0]  out_be,
   output logic        misalign,
   output logic [31:0] misalign_addr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          misalign_q;
   logic [31:0]   misalign_addr_q;

   logic [31:0]   addr_mem_q  [DEPTH];
   logic [31:0]   wdata_mem_q [DEPTH];
   logic [3:0]    be_mem_q    [DEPTH];

   logic [1:0]    lane;
   logic          fault;
   logic [31:0]   nar_wdata;
   logic [3:0]    nar_be;
   logic          accept;
   logic          push;
   logic          pop;

   // Lane steering and fault detection for the incoming request.
   always_comb begin
      lane      = in_addr[1:0];
      fault     = 1'b0;
      nar_wdata = in_data;
      nar_be    = 4'b1111;
      case (in_size)
         2'b00: begin
            nar_wdata = {4{in_data[7:0]}};
            nar_be    = 4'b0001 << lane;
         end
         2'b01: begin
            nar_wdata = {2{in_data[15:0]}};
            nar_be    = 4'b0011 << lane;
            fault     = in_addr[0];
         end
         2'b10: begin
            fault     = |lane;
         end
         default: begin
            fault     = 1'b1;
         end
      endcase
   end

   assign in_ready  = (count_q < DEPTH_C) & ~reset;
   assign out_valid = (count_q != '0);
   assign accept    = in_valid & in_ready;
   // A faulting request completes its handshake but never enters the queue.
   assign push      = accept & ~fault;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= accept & fault;
         if (accept & fault) begin
            misalign_addr_q <= in_addr;
         end
      end
   end

   // One storage slot per entry; zeroed on reset so the head is never X.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (reset) begin
               addr_mem_q[gi]  <= '0;
               wdata_mem_q[gi] <= '0;
               be_mem_q[gi]    <= '0;
            end else if (push && (wr_ptr_q == AW'(gi))) begin
               addr_mem_q[gi]  <= {in_addr[31:2], 2'b00};
               wdata_mem_q[gi] <= nar_wdata;
               be_mem_q[gi]    <= nar_be;
            end
         end
      end
   endgenerate

   assign out_addr      = addr_mem_q[rd_ptr_q];
   assign out_wdata     = wdata_mem_q[rd_ptr_q];
   assign out_be        = be_mem_q[rd_ptr_q];
   assign misalign      = misalign_q;
   assign misalign_addr = misalign_addr_q;

endmodule
